// File: rtl/fletcher_checksum_pkg.sv
// Shared sizing helpers for the Fletcher checksum engine.
package fletcher_checksum_pkg;

  // Width of each running sum (A and B) for a given total checksum width.
  function automatic int unsigned half_width(input int unsigned width);
    return width / 2;
  endfunction

  // Ones'-complement modulus 2^H - 1 for a given total checksum width.
  function automatic longint unsigned ones_modulus(input int unsigned width);
    return (64'(1) << (width / 2)) - 64'(1);
  endfunction

endpackage

// File: rtl/fletcher_checksum_mod_ones_add.sv
// Combinational modular add: sum = (x + y) mod (2^H - 1).
// x must be canonical (0..M-1); y may be anything up to M (all ones).
module mod_ones_add #(
  parameter int unsigned H = 32
) (
  input  logic [H-1:0] x,
  input  logic [H-1:0] y,
  output logic [H-1:0] sum
);

  localparam logic [H:0] Mod = {1'b0, {H{1'b1}}};

  logic [H:0] s;
  logic       wrap;

  assign s    = {1'b0, x} + {1'b0, y};
  assign wrap = (s >= Mod);

  // Subtracting M modulo 2^H is the same as adding 1, so the conditional
  // subtract reduces to an increment of the low H bits.
  assign sum = s[H-1:0] + {{(H-1){1'b0}}, wrap};

endmodule

// File: rtl/fletcher_checksum.sv
// Streaming Fletcher-16/32/64 engine: one Width/2-bit word per enabled clock,
// registered checksum {B, A} on dout.
module fletcher_checksum
  import fletcher_checksum_pkg::*;
#(
  parameter int unsigned Width = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [Width/2-1:0] din,
  output logic [Width-1:0]   dout
);

  localparam int unsigned H = half_width(Width);

  logic [H-1:0] a_q, b_q;
  logic [H-1:0] a_d, b_d;
  logic [H-1:0] a_next, b_next;

  mod_ones_add #(.H(H)) u_add_a (
    .x  (a_q),
    .y  (din),
    .sum(a_next)
  );

  // B accumulates the freshly updated A, so the adders are chained.
  mod_ones_add #(.H(H)) u_add_b (
    .x  (b_q),
    .y  (a_next),
    .sum(b_next)
  );

  // Next-state select: accumulate on enable, otherwise hold.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (en) begin
      a_d = a_next;
      b_d = b_next;
    end
  end

  // Sum registers with synchronous active-low reset overriding enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign dout = {b_q, a_q};

endmodule

// File: tb/tb_fletcher_checksum.sv
// Scoreboard bench for fletcher_checksum at Width = 64 and Width = 16.
module tb_fletcher_checksum;

  logic        clk = 1'b0;
  logic        rst;
  logic        en64, en16;
  logic [31:0] din64;
  logic [7:0]  din16;
  logic [63:0] dout64;
  logic [15:0] dout16;

  always #5 clk = ~clk;

  fletcher_checksum #(.Width(64)) u_dut64 (
    .clk (clk),
    .rst (rst),
    .en  (en64),
    .din (din64),
    .dout(dout64)
  );

  fletcher_checksum #(.Width(16)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .en  (en16),
    .din (din16),
    .dout(dout16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q64[$];
  logic [63:0] exp_q16[$];

  // Reference model: plain remainder arithmetic on wide integers.
  longint unsigned a64 = 0, b64 = 0, a16 = 0, b16 = 0;
  localparam longint unsigned M64 = 64'h0000_0000_FFFF_FFFF;
  localparam longint unsigned M16 = 64'd255;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Drive one cycle, predict both outputs, then compare after the edge.
  task automatic cycle(input string tag, input logic r, input logic e64, input logic [31:0] d64,
                       input logic e16, input logic [7:0] d16);
    logic [63:0] got64, got16;
    rst   = r;
    en64  = e64;
    din64 = d64;
    en16  = e16;
    din16 = d16;
    if (!r) begin
      a64 = 0; b64 = 0; a16 = 0; b16 = 0;
    end else begin
      if (e64) begin
        a64 = (a64 + longint'(d64)) % M64;
        b64 = (b64 + a64) % M64;
      end
      if (e16) begin
        a16 = (a16 + longint'(d16)) % M16;
        b16 = (b16 + a16) % M16;
      end
    end
    exp_q64.push_back({b64[31:0], a64[31:0]});
    exp_q16.push_back({48'h0, b16[7:0], a16[7:0]});
    @(posedge clk);
    #1;
    got64 = dout64;
    got16 = {48'h0, dout16};
    if (exp_q64.size() == 0 || exp_q16.size() == 0) begin
      check({tag, "_queue"}, 64'(exp_q64.size() + exp_q16.size()), 64'd2);
    end else begin
      check({tag, "_w64"}, got64, exp_q64.pop_front());
      check({tag, "_w16"}, got16, exp_q16.pop_front());
    end
  endtask

  initial begin
    rst = 1'b0; en64 = 1'b0; en16 = 1'b0; din64 = '0; din16 = '0;
    @(posedge clk);
    #1;

    // Reset dominates enable.
    cycle("reset0", 1'b0, 1'b1, $urandom, 1'b1, 8'($urandom));
    cycle("reset1", 1'b0, 1'b1, $urandom, 1'b1, 8'($urandom));
    check("reset_dout64", dout64, 64'h0);
    check("reset_dout16", {48'h0, dout16}, 64'h0);

    // "abcdefgh" packed little-endian into 32-bit words.
    cycle("abcd", 1'b1, 1'b1, 32'h6463_6261, 1'b0, 8'h00);
    check("abcd_const", dout64, 64'h6463_6261_6463_6261);
    cycle("efgh", 1'b1, 1'b1, 32'h6867_6665, 1'b0, 8'h00);
    check("efgh_const", dout64, 64'h312E_2B28_CCCA_C8C6);
    cycle("AAAA", 1'b1, 1'b1, 32'h4141_4141, 1'b0, 8'h00);
    check("both_wrap", dout64, 64'h3F3A_3530_0E0C_0A08);

    // Input changes between edges must not reach dout.
    din64 = 32'hDEAD_BEEF;
    en64  = 1'b1;
    #3;
    check("no_comb_path", dout64, 64'h3F3A_3530_0E0C_0A08);

    // Build A = 5, B = 7, then feed all-ones.
    cycle("rst_ab", 1'b0, 1'b0, 32'h0, 1'b0, 8'h00);
    cycle("feed2", 1'b1, 1'b1, 32'h2, 1'b0, 8'h00);
    cycle("feed3", 1'b1, 1'b1, 32'h3, 1'b0, 8'h00);
    check("a5_b7", dout64, 64'h0000_0007_0000_0005);
    cycle("ones", 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 8'h00);
    check("ones_const", dout64, 64'h0000_000C_0000_0005);
    for (int i = 0; i < 3; i++) begin
      cycle("hold", 1'b1, 1'b0, $urandom, 1'b0, 8'($urandom));
    end
    check("hold_const", dout64, 64'h0000_000C_0000_0005);

    // Zero word leaves A, B still accumulates.
    cycle("zero", 1'b1, 1'b1, 32'h0, 1'b0, 8'h00);
    check("zero_const", dout64, 64'h0000_0011_0000_0005);

    // Modulus boundary: sum equal to M wraps to 0.
    cycle("rst_mod", 1'b0, 1'b0, 32'h0, 1'b0, 8'h00);
    cycle("fffe", 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 8'h00);
    cycle("plus1", 1'b1, 1'b1, 32'h1, 1'b0, 8'h00);
    check("mod_wrap", dout64, 64'hFFFF_FFFE_0000_0000);

    // Random back-to-back stream, then reset mid-stream.
    for (int i = 0; i < 20; i++) begin
      cycle("rand", 1'b1, 1'b1, $urandom, 1'b1, 8'($urandom));
    end
    cycle("mid_rst", 1'b0, 1'b1, $urandom, 1'b1, 8'($urandom));
    cycle("restart", 1'b1, 1'b1, 32'h6463_6261, 1'b0, 8'h00);
    check("restart_const", dout64, 64'h6463_6261_6463_6261);

    // Fletcher-16 reference on "abcde".
    cycle("rst16", 1'b0, 1'b0, 32'h0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cycle("abcde", 1'b1, 1'b0, 32'h0, 1'b1, 8'(8'h61 + i));
    end
    check("f16_ref", {48'h0, dout16}, 64'h0000_0000_0000_C8F0);

    // Width-16 boundary: 0xFF leaves A unchanged, 0xFE + 1 wraps to 0.
    cycle("ff16", 1'b1, 1'b0, 32'h0, 1'b1, 8'hFF);
    cycle("rst16b", 1'b0, 1'b0, 32'h0, 1'b0, 8'h00);
    cycle("fe16", 1'b1, 1'b0, 32'h0, 1'b1, 8'hFE);
    cycle("p1_16", 1'b1, 1'b0, 32'h0, 1'b1, 8'h01);
    check("f16_wrap", {48'h0, dout16}, 64'h0000_0000_0000_FE00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
